// File: rtl/weight_stream_pkg.sv
// Shared types and layer-geometry helpers for the weight layer streamer.
package weight_stream_pkg;

  // Layer codes; LAYER_ALL only appears as a layer-select value.
  typedef enum logic [1:0] {
    LAYER_ALL = 2'd0,
    LAYER_H1  = 2'd1,
    LAYER_H2  = 2'd2,
    LAYER_OUT = 2'd3
  } layer_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int unsigned layer_fan_in(input layer_e layer, input int unsigned ni,
                                               input int unsigned n1, input int unsigned n2);
    case (layer)
      LAYER_H2:  return n1;
      LAYER_OUT: return n2;
      default:   return ni;
    endcase
  endfunction

  function automatic int unsigned layer_nodes(input layer_e layer, input int unsigned n1,
                                              input int unsigned n2, input int unsigned no);
    case (layer)
      LAYER_H2:  return n2;
      LAYER_OUT: return no;
      default:   return n1;
    endcase
  endfunction

  // Words in a layer: one weight per input plus a bias per node.
  function automatic int unsigned layer_size(input layer_e layer, input int unsigned ni,
                                             input int unsigned n1, input int unsigned n2,
                                             input int unsigned no);
    return layer_nodes(layer, n1, n2, no) * (layer_fan_in(layer, ni, n1, n2) + 1);
  endfunction

  // Layers are packed back to back in the flat memory.
  function automatic int unsigned layer_base(input layer_e layer, input int unsigned ni,
                                             input int unsigned n1, input int unsigned n2,
                                             input int unsigned no);
    case (layer)
      LAYER_H2:  return layer_size(LAYER_H1, ni, n1, n2, no);
      LAYER_OUT: return layer_size(LAYER_H1, ni, n1, n2, no) +
                        layer_size(LAYER_H2, ni, n1, n2, no);
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid buffer holding {layer, addr, data} words; head drives the stream output.
module weight_skid_fifo #(
  parameter int unsigned WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  // Zero when empty so stale entries never show on the output bus.
  assign out_data  = out_valid ? head_q : '0;

  // Entry storage and occupancy; flush has priority over any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_layer_streamer.sv
// Streams weights from a flat 1-cycle-latency memory to main_net, tagged with layer code and
// in-layer address, under valid/ready backpressure. Optional feature macro:
// WEIGHT_STREAM_CHECKSUM_EN adds o_checksum, the XOR of every accepted word.
module weight_layer_streamer #(
  parameter int unsigned DATA_WIDTH                    = 32,
  parameter int unsigned LAYER_WIDTH                   = 2,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [LAYER_WIDTH-1:0]          i_layer_sel,
  input  logic                            i_abort,
  output logic                            o_mem_rd_en,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]           i_mem_rd_data,
  output logic                            o_weight_valid,
  input  logic                            i_weight_ready,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic                            o_busy,
  output logic                            o_load_weight_done
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]           o_checksum
`endif
);

  import weight_stream_pkg::*;

  localparam int unsigned LW  = LAYER_WIDTH;
  localparam int unsigned WCW = WEIGHT_COUNTER_WIDTH;
  localparam int unsigned NI  = NUMBER_OF_INPUT_NODE;
  localparam int unsigned N1  = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int unsigned N2  = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int unsigned NO  = NUMBER_OF_OUTPUT_NODE;
  localparam int unsigned FW  = LW + WCW + DATA_WIDTH;

  localparam int unsigned Size1 = layer_size(LAYER_H1, NI, N1, N2, NO);
  localparam int unsigned Size2 = layer_size(LAYER_H2, NI, N1, N2, NO);
  localparam int unsigned Size3 = layer_size(LAYER_OUT, NI, N1, N2, NO);
  localparam int unsigned Base2 = layer_base(LAYER_H2, NI, N1, N2, NO);
  localparam int unsigned Base3 = layer_base(LAYER_OUT, NI, N1, N2, NO);
  localparam int unsigned Total = Base3 + Size3;

  if (Total > (1 << WCW)) begin : g_param_check
    $error("weight_layer_streamer: total weight words exceed 2**WEIGHT_COUNTER_WIDTH");
  end

  localparam logic [WCW-1:0] Last1  = WCW'(Size1 - 1);
  localparam logic [WCW-1:0] Last2  = WCW'(Size2 - 1);
  localparam logic [WCW-1:0] Last3  = WCW'(Size3 - 1);
  localparam logic [WCW-1:0] BaseV2 = WCW'(Base2);
  localparam logic [WCW-1:0] BaseV3 = WCW'(Base3);
  localparam logic [LW-1:0]  CodeH1 = LW'(LAYER_H1);
  localparam logic [LW-1:0]  CodeH2 = LW'(LAYER_H2);
  localparam logic [LW-1:0]  CodeO  = LW'(LAYER_OUT);

  state_e         state_q;
  logic [LW-1:0]  cur_layer_q;
  logic [WCW-1:0] cur_addr_q;
  logic           all_mode_q;
  logic           busy_q;
  logic           done_q;
  logic           in_flight_q;
  logic [LW-1:0]  rd_layer_q;
  logic [WCW-1:0] rd_addr_q;

  logic [WCW-1:0] cur_last, cur_base;
  logic           last_in_layer, last_read;
  logic           rd_en, pop, room, flush;
  logic [1:0]     fifo_count;
  logic [FW-1:0]  fifo_out;

  // Geometry of the layer currently being read.
  always_comb begin
    cur_last = Last1;
    cur_base = '0;
    case (cur_layer_q)
      CodeH2: begin
        cur_last = Last2;
        cur_base = BaseV2;
      end
      CodeO: begin
        cur_last = Last3;
        cur_base = BaseV3;
      end
      default: ;
    endcase
  end

  assign last_in_layer = (cur_addr_q == cur_last);
  assign last_read     = last_in_layer && (!all_mode_q || cur_layer_q == CodeO);
  assign pop           = o_weight_valid & i_weight_ready;
  // Issue only if the word is guaranteed a buffer slot when it returns.
  assign room          = ({1'b0, fifo_count} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop});
  assign rd_en         = (state_q == RUN) && !i_abort && room;
  assign flush         = i_abort && (state_q == RUN || state_q == DRAIN);

  assign o_mem_rd_en        = rd_en;
  assign o_mem_addr         = rd_en ? (cur_base + cur_addr_q) : '0;
  assign o_busy             = busy_q;
  assign o_load_weight_done = done_q;

  // Control FSM: read sequencing, done flag and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_layer_q <= '0;
      cur_addr_q  <= '0;
      all_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_abort) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cur_addr_q  <= '0;
            all_mode_q  <= (i_layer_sel == '0);
            cur_layer_q <= (i_layer_sel == '0) ? CodeH1 : i_layer_sel;
          end
        end
        RUN: begin
          if (i_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (rd_en) begin
            if (last_read) begin
              state_q <= DRAIN;
            end else if (last_in_layer) begin
              cur_layer_q <= cur_layer_q + LW'(1);
              cur_addr_q  <= '0;
            end else begin
              cur_addr_q <= cur_addr_q + WCW'(1);
            end
          end
        end
        DRAIN: begin
          if (i_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (pop && fifo_count == 2'd1 && !in_flight_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag each issued read so the returning word carries its layer and in-layer address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= 1'b0;
      rd_layer_q  <= '0;
      rd_addr_q   <= '0;
    end else begin
      in_flight_q <= rd_en;
      if (rd_en) begin
        rd_layer_q <= cur_layer_q;
        rd_addr_q  <= cur_addr_q;
      end
    end
  end

  weight_skid_fifo #(
    .WIDTH(FW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (in_flight_q),
    .push_data({rd_layer_q, rd_addr_q, i_mem_rd_data}),
    .out_ready(i_weight_ready),
    .out_valid(o_weight_valid),
    .out_data (fifo_out),
    .count    (fifo_count)
  );

  assign {o_weight_layer, o_weight_addr, o_weight} = fifo_out;

`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;
  assign o_checksum = checksum_q;

  // Running XOR of accepted words, restarted by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (state_q == IDLE && i_start && !i_abort) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ o_weight;
    end
  end
`endif

endmodule

// File: tb/tb_weight_layer_streamer.sv
// Directed bench for weight_layer_streamer; memory model returns the flat address as data.
module tb_weight_layer_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_layer_sel;
  logic        i_abort;
  logic        o_mem_rd_en;
  logic [10:0] o_mem_addr;
  logic [31:0] i_mem_rd_data;
  logic        o_weight_valid;
  logic        i_weight_ready;
  logic [1:0]  o_weight_layer;
  logic [10:0] o_weight_addr;
  logic [31:0] o_weight;
  logic        o_busy;
  logic        o_load_weight_done;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  int n_vec = 0;
  int n_err = 0;
  int first_valid_cyc;
  int done_cyc;

  always #5 clk = ~clk;

  weight_layer_streamer dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_layer_sel       (i_layer_sel),
    .i_abort           (i_abort),
    .o_mem_rd_en       (o_mem_rd_en),
    .o_mem_addr        (o_mem_addr),
    .i_mem_rd_data     (i_mem_rd_data),
    .o_weight_valid    (o_weight_valid),
    .i_weight_ready    (i_weight_ready),
    .o_weight_layer    (o_weight_layer),
    .o_weight_addr     (o_weight_addr),
    .o_weight          (o_weight),
    .o_busy            (o_busy),
    .o_load_weight_done(o_load_weight_done)
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    ,
    .o_checksum        (o_checksum)
`endif
  );

  // Flat memory whose content equals its address, 1-cycle read latency.
  always @(posedge clk) begin
    if (o_mem_rd_en) i_mem_rd_data <= 32'(o_mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Expected {layer, in-layer addr, data} for flat word index (sizes 96 / 1056 / 99).
  function automatic logic [63:0] exp_word(input int flat);
    logic [1:0]  l;
    logic [10:0] a;
    if (flat < 96) begin
      l = 2'd1;
      a = 11'(flat);
    end else if (flat < 1152) begin
      l = 2'd2;
      a = 11'(flat - 96);
    end else begin
      l = 2'd3;
      a = 11'(flat - 1152);
    end
    return 64'({l, a, 32'(flat)});
  endfunction

  function automatic logic [63:0] cur_word();
    return 64'({o_weight_layer, o_weight_addr, o_weight});
  endfunction

  // Start a load and follow it to completion, checking every handshake and every stall.
  task automatic run_load(input logic [1:0] sel, input int first, input int nwords,
                          input bit rnd);
    int          got;
    int          cyc;
    bit          held_v;
    logic [63:0] held;
    logic [63:0] w;
    got = 0;
    cyc = 0;
    held_v = 0;
    held = '0;
    first_valid_cyc = -1;
    i_weight_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b1;
    i_layer_sel = sel;
    @(negedge clk);
    i_start = 1'b0;
    while (got < nwords && cyc < 8000) begin
      if (cyc == 0) check("first_read", 64'({o_mem_rd_en, o_mem_addr}), 64'({1'b1, 11'(first)}));
      w = cur_word();
      if (held_v) check("hold", {o_weight_valid, w[62:0]}, {1'b1, held[62:0]});
      i_weight_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_weight_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_weight_valid && i_weight_ready) begin
        check("word", w, exp_word(first + got));
        got++;
        held_v = 0;
      end else if (o_weight_valid) begin
        held_v = 1;
        held = w;
      end else begin
        held_v = 0;
      end
      @(negedge clk);
      cyc++;
    end
    done_cyc = cyc;
    check("word_count", 64'(got), 64'(nwords));
    check("done_flags", 64'({o_load_weight_done, o_busy, o_weight_valid}), 64'(3'b100));
    @(negedge clk);
    check("done_held", 64'({o_load_weight_done, o_busy, o_weight_valid}), 64'(3'b100));
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    i_start = 1'b0;
    i_layer_sel = 2'd0;
    i_abort = 1'b0;
    i_weight_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({o_mem_rd_en, o_mem_addr, o_weight_valid, o_weight_layer, o_weight_addr,
               o_weight, o_busy, o_load_weight_done}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: full load, ready held high.
    run_load(2'd0, 0, 1251, 1'b0);
    check("t1_first_valid_cycle", 64'(first_valid_cyc), 64'(2));
    check("t1_done_cycle", 64'(done_cyc), 64'(1253));
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    check("t6_checksum", 64'(o_checksum), 64'(32'h0000_04E3));
`endif

    // 2: full load, random ready.
    run_load(2'd0, 0, 1251, 1'b1);

    // 3: single-layer reload of hidden layer 2.
    run_load(2'd2, 96, 1056, 1'b0);

    // 4: abort at layer 2 addr 200, then a clean full restart.
    @(negedge clk);
    i_weight_ready = 1'b1;
    i_start = 1'b1;
    i_layer_sel = 2'd0;
    @(negedge clk);
    i_start = 1'b0;
    check("t4_done_cleared", 64'(o_load_weight_done), 64'(0));
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (o_weight_valid && o_weight_layer == 2'd2 && o_weight_addr == 11'd200) found = 1;
      else @(negedge clk);
    end
    check("t4_abort_point", 64'(found), 64'(1));
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("t4_after_abort", 64'({o_weight_valid, o_busy, o_load_weight_done, o_mem_rd_en}),
          64'(0));
    repeat (3) @(negedge clk);
    check("t4_no_stale", 64'({o_weight_valid, o_busy, o_load_weight_done}), 64'(0));
    run_load(2'd0, 0, 1251, 1'b0);

    // 5: reset while a read is in flight.
    @(negedge clk);
    i_start = 1'b1;
    i_layer_sel = 2'd0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_read_pending", 64'(o_mem_rd_en), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_reset_outputs",
          64'({o_mem_rd_en, o_mem_addr, o_weight_valid, o_weight_layer, o_weight_addr,
               o_weight, o_busy, o_load_weight_done}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_quiet_after_reset", 64'({o_weight_valid, o_busy, o_mem_rd_en}), 64'(0));
    run_load(2'd0, 0, 1251, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
